// File: rtl/npu_host_master_if.sv
// npu_host_master_if: command, response and BRAM host-port signals of the host initiator.
interface npu_host_master_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic [DATA_W-1:0] cmd_mask;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [1:0]        rsp_status;
    logic              busy;
    logic              ena;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic [DATA_W-1:0] douta;
    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask, rsp_ready, douta,
        output cmd_ready, rsp_valid, rsp_data, rsp_status, busy, ena, wea, addra, dina
    );
    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask, rsp_ready, douta,
        input  cmd_ready, rsp_valid, rsp_data, rsp_status, busy, ena, wea, addra, dina
    );
endinterface

// File: rtl/npu_host_master.sv
// npu_host_master: executes WRITE/READ/POLL commands as NPU host-port transactions, one response each.
module npu_host_master #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int RD_LAT       = 1,
    parameter int POLL_TIMEOUT = 1023,
    parameter int POLL_GAP     = 2
) (
    input logic clk,
    input logic rst,
    npu_host_master_if.master h
);
    typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_WAIT, GAP, RESP} state_t;
    state_t            state, state_n;
    logic [1:0]        op, op_n, status_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [DATA_W-1:0] data, data_n, mask, mask_n, rdata_n;
    logic [15:0]       n, n_n;
    logic [7:0]        cnt, cnt_n;
    logic              accept, match, timeout, issue_n;
    assign accept  = h.cmd_ready && h.cmd_valid;
    assign match   = ((h.douta ^ data) & mask) == '0;
    assign timeout = n == 16'(POLL_TIMEOUT);
    assign issue_n = state_n == WR || state_n == RD_ISSUE;
    always_comb begin
        state_n  = state;
        op_n     = op;
        addr_n   = addr;
        data_n   = data;
        mask_n   = mask;
        n_n      = n;
        cnt_n    = cnt;
        rdata_n  = h.rsp_data;
        status_n = h.rsp_status;
        case (state)
            IDLE: if (accept) begin
                op_n     = h.cmd_op;
                addr_n   = h.cmd_addr;
                data_n   = h.cmd_data;
                mask_n   = h.cmd_mask;
                n_n      = '0;
                rdata_n  = '0;
                status_n = h.cmd_op == 2'b11 ? 2'b10 : 2'b00;
                state_n  = h.cmd_op == 2'b00 ? WR : h.cmd_op == 2'b11 ? RESP : RD_ISSUE;
            end
            WR: begin
                rdata_n  = data;
                status_n = 2'b00;
                state_n  = RESP;
            end
            RD_ISSUE: begin
                n_n     = n + 16'd1;
                cnt_n   = '0;
                state_n = RD_WAIT;
            end
            RD_WAIT: if (cnt == 8'(RD_LAT - 1)) begin
                // a READ always finishes on its single sample; a POLL retries until match or timeout
                rdata_n  = h.douta;
                status_n = op == 2'b10 && !match && timeout ? 2'b01 : 2'b00;
                cnt_n    = '0;
                state_n  = op == 2'b01 || match || timeout ? RESP : POLL_GAP == 0 ? RD_ISSUE : GAP;
            end else cnt_n = cnt + 8'd1;
            GAP: begin
                cnt_n   = cnt + 8'd1;
                state_n = cnt == 8'(POLL_GAP - 1) ? RD_ISSUE : GAP;
            end
            RESP: state_n = h.rsp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            op           <= '0;
            addr         <= '0;
            data         <= '0;
            mask         <= '0;
            n            <= '0;
            cnt          <= '0;
            h.cmd_ready  <= 1'b0;
            h.busy       <= 1'b0;
            h.rsp_valid  <= 1'b0;
            h.rsp_data   <= '0;
            h.rsp_status <= '0;
            h.ena        <= 1'b0;
            h.wea        <= 1'b0;
            h.addra      <= '0;
            h.dina       <= '0;
        end else begin
            state        <= state_n;
            op           <= op_n;
            addr         <= addr_n;
            data         <= data_n;
            mask         <= mask_n;
            n            <= n_n;
            cnt          <= cnt_n;
            h.cmd_ready  <= state_n == IDLE;
            h.busy       <= state_n != IDLE;
            h.rsp_valid  <= state_n == RESP;
            h.rsp_data   <= rdata_n;
            h.rsp_status <= status_n;
            h.ena        <= issue_n;
            h.wea        <= state_n == WR;
            h.addra      <= issue_n ? addr_n : '0;
            h.dina       <= state_n == WR ? data_n : '0;
        end
    end
endmodule

// File: tb/tb_npu_host_master.sv
// tb_npu_host_master: directed scoreboard bench for the host-port initiator.
module tb_npu_host_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    npu_host_master_if #(.ADDR_W(16), .DATA_W(32)) b ();
    npu_host_master_if #(.ADDR_W(16), .DATA_W(32)) b2 ();
    npu_host_master #(.ADDR_W(16), .DATA_W(32), .RD_LAT(1), .POLL_TIMEOUT(4), .POLL_GAP(2))
        dut (.clk(clk), .rst(rst), .h(b));
    npu_host_master #(.ADDR_W(16), .DATA_W(32), .RD_LAT(3), .POLL_TIMEOUT(1023), .POLL_GAP(2))
        dut3 (.clk(clk), .rst(rst), .h(b2));
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int t_acc = 0;
    int overlap = 0;
    int ena2 = 0;
    logic [31:0] rd_vals[$];
    logic [31:0] rd_dflt = 32'h0;
    logic [31:0] pipe3[3];
    int          iss_cyc[$];
    logic        iss_we[$];
    logic [15:0] iss_addr[$];
    logic [31:0] iss_din[$];
    logic [33:0] sb[$];
    always @(posedge clk) cyc <= cyc + 1;
    // read-data model: valid only in the cycle RD_LAT after an issue, junk otherwise
    always @(posedge clk) begin
        if (b.ena && !b.wea) begin
            if (rd_vals.size() > 0) b.douta <= rd_vals.pop_front();
            else b.douta <= rd_dflt;
        end else b.douta <= 32'hBAD0BAD0;
    end
    always @(posedge clk) begin
        pipe3[0] <= (b2.ena && !b2.wea) ? 32'hDEADBEEF : 32'h0;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign b2.douta = pipe3[2];
    always @(posedge clk) begin
        #2;
        if (b.ena) begin
            iss_cyc.push_back(cyc);
            iss_we.push_back(b.wea);
            iss_addr.push_back(b.addra);
            iss_din.push_back(b.dina);
        end
        if (b.ena && b.rsp_valid) overlap++;
        if (b2.ena) ena2++;
    end
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [31:0] d, input logic [31:0] m);
        int k = 0;
        iss_cyc.delete();
        iss_we.delete();
        iss_addr.delete();
        iss_din.delete();
        b.cmd_op = op;
        b.cmd_addr = a;
        b.cmd_data = d;
        b.cmd_mask = m;
        b.cmd_valid = 1'b1;
        while (!b.cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("cmd_accept", k < 50, 1);
        t_acc = cyc;
        @(negedge clk);
        b.cmd_valid = 1'b0;
        b.cmd_op = 2'b11;
        b.cmd_addr = 16'hFFFF;
        b.cmd_data = $urandom;
        b.cmd_mask = $urandom;
    endtask
    task automatic wait_rsp(input int lat);
        int k = 0;
        logic [33:0] e;
        while (!b.rsp_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        e = sb.pop_front();
        chk("rsp_latency", cyc - t_acc, lat);
        chk("rsp_data", b.rsp_data, e[31:0]);
        chk("rsp_status", b.rsp_status, e[33:32]);
    endtask
    task automatic chk_iss(input int cnt, input int gap, input logic we, input logic [15:0] a, input logic [31:0] d);
        chk("issue_count", iss_cyc.size(), cnt);
        for (int i = 0; i < iss_cyc.size(); i++) begin
            chk("issue_cycle", iss_cyc[i] - t_acc, 1 + i * gap);
            chk("issue_wea", iss_we[i], we);
            chk("issue_addr", iss_addr[i], a);
            chk("issue_din", iss_din[i], we ? d : 32'h0);
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int k;
        logic seen;
        b.cmd_valid = 0; b.cmd_op = 0; b.cmd_addr = 0; b.cmd_data = 0; b.cmd_mask = 0; b.rsp_ready = 1;
        b2.cmd_valid = 0; b2.cmd_op = 0; b2.cmd_addr = 0; b2.cmd_data = 0; b2.cmd_mask = 0; b2.rsp_ready = 1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_cmd_ready", b.cmd_ready, 0);
        chk("reset_rsp_valid", b.rsp_valid, 0);
        chk("reset_bus", {b.ena, b.wea, b.addra, b.dina}, 0);
        chk("reset_busy", b.busy, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_cmd_ready", b.cmd_ready, 1);
        // WRITE
        sb.push_back({2'b00, 32'h04030201});
        send(2'b00, 16'h1005, 32'h04030201, 32'h0);
        wait_rsp(2);
        chk_iss(1, 0, 1'b1, 16'h1005, 32'h04030201);
        @(negedge clk);
        chk("write_ready_t3", b.cmd_ready, 1);
        // READ, RD_LAT=1
        rd_vals.push_back(32'hDEADBEEF);
        sb.push_back({2'b00, 32'hDEADBEEF});
        send(2'b01, 16'h5000, 32'h0, 32'h0);
        wait_rsp(3);
        chk_iss(1, 0, 1'b0, 16'h5000, 32'h0);
        @(negedge clk);
        // POLL that matches on the fourth read
        rd_vals = '{32'h0, 32'h0, 32'h0, 32'h1};
        sb.push_back({2'b00, 32'h1});
        send(2'b10, 16'h5001, 32'h1, 32'h1);
        wait_rsp(15);
        chk_iss(4, 4, 1'b0, 16'h5001, 32'h0);
        @(negedge clk);
        // POLL timeout after exactly four reads
        rd_vals.delete();
        rd_dflt = 32'h0;
        sb.push_back({2'b01, 32'h0});
        send(2'b10, 16'h5001, 32'h1, 32'h1);
        wait_rsp(15);
        repeat (8) @(negedge clk);
        chk_iss(4, 4, 1'b0, 16'h5001, 32'h0);
        // POLL with zero mask matches immediately
        rd_vals.push_back(32'h00001234);
        sb.push_back({2'b00, 32'h00001234});
        send(2'b10, 16'h5002, 32'hFFFF, 32'h0);
        wait_rsp(3);
        chk_iss(1, 0, 1'b0, 16'h5002, 32'h0);
        @(negedge clk);
        // backpressure on a READ response
        b.rsp_ready = 1'b0;
        rd_vals.push_back(32'hCAFEF00D);
        sb.push_back({2'b00, 32'hCAFEF00D});
        send(2'b01, 16'h2003, 32'h0, 32'h0);
        wait_rsp(3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", b.rsp_valid, 1);
            chk("bp_rsp", {b.rsp_status, b.rsp_data}, {2'b00, 32'hCAFEF00D});
            chk("bp_cmd_ready", b.cmd_ready, 0);
            chk("bp_ena", b.ena, 0);
        end
        b.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", b.cmd_ready, 1);
        chk("bp_release_valid", b.rsp_valid, 0);
        // illegal op
        sb.push_back({2'b10, 32'h0});
        send(2'b11, 16'h1234, 32'hFFFFFFFF, 32'h0);
        wait_rsp(1);
        chk("illegal_no_issue", iss_cyc.size(), 0);
        @(negedge clk);
        // reset during POLL gap
        rd_dflt = 32'h0;
        send(2'b10, 16'h5001, 32'h1, 32'h1);
        @(negedge clk);
        @(negedge clk);
        chk("gap_busy", b.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_bus", {b.ena, b.wea, b.addra, b.dina}, 0);
        chk("rst_rsp", {b.rsp_valid, b.rsp_status, b.rsp_data}, 0);
        chk("rst_busy_ready", {b.busy, b.cmd_ready}, 0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (b.rsp_valid) seen = 1'b1;
        end
        chk("rst_no_response", seen, 0);
        chk("rst_single_read", iss_cyc.size(), 1);
        sb.push_back({2'b00, 32'hA5A55A5A});
        send(2'b00, 16'h2001, 32'hA5A55A5A, 32'h0);
        wait_rsp(2);
        chk_iss(1, 0, 1'b1, 16'h2001, 32'hA5A55A5A);
        @(negedge clk);
        // READ through the RD_LAT=3 instance
        ena2 = 0;
        b2.cmd_op = 2'b01;
        b2.cmd_addr = 16'h5000;
        b2.cmd_valid = 1'b1;
        k = 0;
        while (!b2.cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        t_acc = cyc;
        @(negedge clk);
        b2.cmd_valid = 1'b0;
        k = 0;
        while (!b2.rsp_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("lat3_latency", cyc - t_acc, 5);
        chk("lat3_rsp", {b2.rsp_status, b2.rsp_data}, {2'b00, 32'hDEADBEEF});
        chk("lat3_issues", ena2, 1);
        @(negedge clk);
        chk("ena_during_rsp", overlap, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/npu_host_master.md
Name: npu_host_master

Overview:
- Host-side initiator for the NPU's BRAM-style host port. Drives `ena`/`wea`/`addra`/`dina` and samples `douta`.
- Takes single commands (WRITE, READ, POLL) from a valid/ready command channel, executes each as bus transactions, and returns one response per command.
- Sits between the test/CPU sequencer and the NPU. Handles image/weight loading (sel 001–100) and control pulses/status polling (sel 101) without software cycle-counting.

Parameters:
- ADDR_W, 16, host port address width (`addra[14:12]` = sel, `addra[11:0]` = word idx).
- DATA_W, 32, host port data width.
- RD_LAT, 1, cycles from read-issue cycle to valid `douta` (legal 1..4).
- POLL_TIMEOUT, 1023, maximum bus reads per POLL before giving up (legal 1..65535).
- POLL_GAP, 2, idle cycles between successive poll reads (legal 0..255).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when `cmd_valid && cmd_ready`.
- cmd_op  in  2  00=WRITE, 01=READ, 10=POLL, 11=illegal.
- cmd_addr  in  ADDR_W  target host-port address.
- cmd_data  in  DATA_W  write data (WRITE) / compare value (POLL).
- cmd_mask  in  DATA_W  POLL compare mask; ignored otherwise.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when `rsp_valid && rsp_ready`.
- rsp_data  out  DATA_W  WRITE: echoed data; READ/POLL: last sampled `douta`; illegal: 0.
- rsp_status  out  2  00=OK, 01=POLL timeout, 10=illegal op.
- busy  out  1  high whenever state != IDLE.
- ena  out  1  host port enable.
- wea  out  1  host port write enable.
- addra  out  ADDR_W  host port address.
- dina  out  DATA_W  host port write data.
- douta  in  DATA_W  host port read data.

Behaviour:
- Reset: on any clk edge with `rst`=1, all registers clear. `cmd_ready`=0 during reset, 1 the first cycle after. `rsp_valid`=0, `rsp_data`=0, `rsp_status`=0, `busy`=0, `ena`=0, `wea`=0, `addra`=0, `dina`=0.
- Reset mid-operation: the in-flight command is dropped, no response is produced, and bus outputs are 0 from the next cycle.
- All outputs are registered. `cmd_ready`=1 only in IDLE. Command fields are latched on acceptance; later changes on `cmd_*` are ignored.
- Bus idle rule: `ena`=`wea`=0 and `addra`=`dina`=0 in every cycle that is not an issue cycle.
- States: IDLE, WR, RD_ISSUE, RD_WAIT, GAP, RESP.
- WRITE (accepted in cycle T):
  - T+1 (WR): `ena`=1, `wea`=1, `addra`=cmd_addr, `dina`=cmd_data for exactly one cycle.
  - T+2: RESP with `rsp_data`=cmd_data, `rsp_status`=00.
- READ (accepted in cycle T):
  - T+1 (RD_ISSUE): `ena`=1, `wea`=0, `addra`=cmd_addr.
  - RD_WAIT counts RD_LAT cycles; `douta` is sampled on the edge ending cycle T+1+RD_LAT.
  - Next cycle: RESP, `rsp_data`=sample, `rsp_status`=00.
- POLL: same issue/sample as READ, plus a 16-bit read counter n (incremented on each issue).
  - Match when `(sample & cmd_mask) == (cmd_data & cmd_mask)` → RESP, status 00.
  - Else if n == POLL_TIMEOUT → RESP, status 01, `rsp_data`=last sample.
  - Else → GAP for POLL_GAP cycles (skipped when 0), then RD_ISSUE at the same address.
  - Read spacing: 1+RD_LAT+POLL_GAP cycles between issue cycles.
  - `cmd_mask`=0 matches on the first read.
- Illegal op (accepted in cycle T): no bus activity; T+1 RESP, `rsp_data`=0, `rsp_status`=10.
- RESP:
  - `rsp_valid`=1, with `rsp_data`/`rsp_status` stable until `rsp_ready`.
  - On handshake the next cycle is IDLE (`cmd_ready`=1).
  - While `rsp_valid` is high, no new command is accepted and there is no bus activity.
- Throughput: minimum 3 cycles per WRITE with `rsp_ready` tied high (accept, issue, resp).
- Address/data pass through unmodified. The block does not decode sel or range-check idx; write-only regions read back whatever the NPU returns.
- Simultaneous `rst` and `cmd_valid`: reset wins, command not accepted.

Test Plan:
- WRITE addr 0x1005, data 0x04030201, `rsp_ready`=1 → exactly one cycle `ena`=`wea`=1, `addra`=0x1005, `dina`=0x04030201 at T+1; `rsp_valid` at T+2 with status 00 and data 0x04030201; `cmd_ready` high at T+3.
- READ addr 0x5000, RD_LAT=1 and 3, memory model returns 0xDEADBEEF → one cycle `ena`=1/`wea`=0; `rsp_data`=0xDEADBEEF, status 00, `rsp_valid` at T+2+RD_LAT.
- POLL addr 0x5001, mask 0x1, value 0x1; model returns 0,0,0,1 → 4 read issues spaced 1+RD_LAT+POLL_GAP cycles apart; `rsp_data`=1, status 00.
- POLL with POLL_TIMEOUT=4 and model always 0 → exactly 4 bus reads, then status 01, `rsp_data`=0; no 5th read.
- Backpressure: hold `rsp_ready`=0 for 5 cycles after a READ → `rsp_*` stable, `cmd_ready`=0, `ena`=0 throughout; handshake on cycle 6 → IDLE next cycle.
- `cmd_op`=11 → no `ena`, status 10, data 0. Separately, assert `rst` for 1 cycle during POLL GAP → all outputs 0 next cycle, no response, next WRITE completes normally.
